id_stage_pipe: RTL and testbench
================================

# id_stage_pipe

Parametrised MIPS instruction-decode stage: register file, operand read with write-back bypass, immediate extension, destination selection, and a registered ID/EX output with valid/ready handshake. Sits between the IF stage (instruction source) and EX. Adds load-use stall detection and flush, giving a pipelined CPU correct one-cycle decode.

## Interface
- `DATA_W`, default 32: register and operand width; must be at least 32.
- `REG_N`, default 32: register count; `AW = $clog2(REG_N)`, with `AW >= 5`.
- `CLK` in, 1: clock, rising edge.
- `RST` in, 1: reset, asynchronous, active-low.
- `in_valid` in, 1: `Ins` is valid.
- `in_ready` out, 1: stage accepts `Ins` this cycle.
- `Ins` in, 32: instruction word.
- `flush` in, 1: discard the ID/EX contents and the current input.
- `wb_en` in, 1: write-back enable.
- `wb_addr` in, AW: write-back register address.
- `wb_data` in, DATA_W: write-back data.
- `ex_ready` in, 1: EX accepts the output.
- `out_valid` out, 1: ID/EX register holds a valid instruction.
- `Rdata1` out, DATA_W: rs operand.
- `Rdata2` out, DATA_W: rt operand.
- `Ed32` out, DATA_W: extended immediate.
- `op` out, 6; `funct` out, 6; `shamt` out, 5: decoded instruction fields.
- `dst` out, AW: destination register.
- `wr_en` out, 1: the instruction writes `dst`.
- `is_load` out, 1: the instruction is `lw`.
- `jaddr` out, 26: `Ins[25:0]`.

## Operation
- **Register file**
  - REG_N×DATA_W storage; all entries cleared asynchronously by `RST`.
  - Written on the `CLK` edge when `wb_en` is high and `wb_addr != 0`.
  - Register 0 always reads 0.
- **Bypass:** a read whose address equals `wb_addr`, with `wb_en` high and address ≠ 0, returns `wb_data` in the same cycle.
- **Ed32 rules**
  - Sign-extend `Ins[15:0]` for addi 0x08, addiu 0x09, slti 0x0A, sltiu 0x0B, beq 0x04, bne 0x05, lw 0x23, sw 0x2B.
  - Zero-extend for andi 0x0C, ori 0x0D, xori 0x0E.
  - lui 0x0F gives `{imm,16'b0}`, sign-extended to DATA_W.
  - All other opcodes give 0.
- **dst / wr_en rules**
  - R-type (op 0): `dst = rd`.
  - jal 0x03: `dst = 31`.
  - addi..lui and lw: `dst = rt`.
  - sw, beq, bne, j 0x02: `wr_en = 0`, `dst = 0`.
  - `wr_en` is forced to 0 whenever `dst == 0`.
- **Source usage**
  - rs is used by every opcode except j, jal, lui.
  - rt is used by R-type, sw, beq, bne.
- **Load-use stall:** `stall` is asserted when `out_valid && is_load && wr_en` and a used source of `Ins` equals `dst`.
- **in_ready** is `RST && !flush && !stall && (!out_valid || ex_ready)`, combinational.
- **Transfer** happens when `in_valid && in_ready`; the ID/EX register loads the decoded fields and sets `out_valid = 1`.
- **Drain:** when `out_valid && ex_ready` and no transfer occurs, `out_valid` goes to 0. During a stall this inserts exactly one bubble.
- **Backpressure:** while `out_valid && !ex_ready`, all outputs hold stable.
- **flush:** at the next edge `out_valid` becomes 0 and no transfer occurs. `flush` overrides stall and transfer. The register-file write still occurs.
- Unrecognised opcodes decode as no-write with `Ed32 = 0`; no exception is raised.

## Timing
- One-cycle latency: an instruction accepted at edge N appears on the outputs after edge N.
- Register-file write and ID/EX capture happen on the same edge. The bypass lets an instruction being captured see the write-back value of that edge.
- Reset values: `out_valid` 0 and all data/field outputs 0, applied immediately on `RST` low without waiting for a clock edge. `in_ready` is 0 while `RST` is low.
- A stall lasts exactly one cycle when `ex_ready = 1`. It persists while the load is held by `!ex_ready`.
- Reset mid-stall or mid-backpressure: the stage returns to empty and all registers are cleared.

## Structure
- Package `mips_pkg` holds:
  - opcode constants (`OP_RTYPE`, `OP_J`, `OP_JAL`, `OP_BEQ`, `OP_BNE`, `OP_ADDI`…`OP_LUI`, `OP_LW`, `OP_SW`);
  - `REG_RA = 31`;
  - the ID/EX struct typedef.
- Sub-module `regfile_2r1w`: two read ports, one write port, asynchronous clear, r0 hardwired to zero, write-to-read bypass.
- Decode, stall logic and the ID/EX register live in `id_stage_pipe`.

## Test plan
- **Bypass:** reset, then `wb_en = 1`, `wb_addr = 5`, `wb_data = 0x1234` while `Ins = 0x00A01820` (add $3,$5,$0) is accepted. Required next cycle: `Rdata1 = 0x1234`, `dst = 3`, `wr_en = 1`.
- **Immediate extension**
  - `0x2022FFFC` gives `Ed32 = 0xFFFFFFFC`.
  - `0x3422FFFC` gives `0x0000FFFC`.
  - `0x3C021234` gives `0x12340000`.
  - `0xAC220008` (sw) gives `wr_en = 0`.
- **Load-use stall:** `0x8C240000` (lw $4) followed by `0x00842820` (add $5,$4,$4), with `in_valid` and `ex_ready` held at 1. Required: `in_ready` low for one cycle, one `out_valid = 0` bubble, add output two cycles after lw.
- **Backpressure:** `ex_ready = 0` for 3 cycles with `out_valid = 1`. Required: outputs unchanged and `in_ready = 0`. When `ex_ready` rises, the next instruction is captured.
- **Register 0 and jal**
  - `wb_addr = 0` with `wb_data = 0xFFFFFFFF`, then reading r0, gives 0.
  - `0x0C000010` (jal) gives `dst = 31`, `wr_en = 1`, `jaddr = 0x10`.
- **Flush and reset:** `flush` asserted with `in_valid` high gives `out_valid = 0` next cycle and the instruction is dropped. `RST` pulled low mid-stream gives `out_valid = 0` with no clock edge, and every register then reads 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode constants, the link register index,
// the ID/EX control-field bundle and the immediate-extension classifier.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [4:0] REG_RA = 5'd31;

    // Destination always comes from a 5-bit instruction field, so it fits here
    // regardless of the register-file address width.
    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic [4:0]  shamt;
        logic [25:0] jaddr;
        logic [4:0]  dst;
        logic        wr_en;
        logic        is_load;
    } id_ex_ctrl_t;

    typedef enum logic [1:0] {
        EXT_NONE,
        EXT_SIGN,
        EXT_ZERO,
        EXT_LUI
    } ext_kind_t;

    function automatic ext_kind_t ext_kind(input logic [5:0] op);
        case (op)
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_BEQ, OP_BNE, OP_LW, OP_SW:  return EXT_SIGN;
            OP_ANDI, OP_ORI, OP_XORI:      return EXT_ZERO;
            OP_LUI:                        return EXT_LUI;
            default:                       return EXT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Two-read, one-write register file with asynchronous clear, r0 tied to zero
// and same-cycle write-to-read bypass.
module regfile_2r1w
    import mips_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int REG_N  = 32,
    localparam int AW     = $clog2(REG_N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     raddr1,
    input  logic [AW-1:0]     raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] mem_q [REG_N];
    logic              wr_hit;

    assign wr_hit = we && (waddr != '0) && (32'(waddr) < REG_N);

    // NOTE: the clear must reach every entry asynchronously, so the storage is
    // built from resettable flops rather than an inferred RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_N; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_hit) begin
            mem_q[waddr] <= wdata;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [AW-1:0] addr);
        if (addr == '0 || 32'(addr) >= REG_N) begin
            return '0;
        end
        if (wr_hit && addr == waddr) begin
            return wdata;
        end
        return mem_q[addr];
    endfunction

    always_comb begin
        rdata1 = read_port(raddr1);
        rdata2 = read_port(raddr2);
    end

endmodule

// File: rtl/id_stage_pipe.sv
// MIPS instruction-decode stage: operand read with bypass, immediate extension,
// destination select, load-use stall and a valid/ready ID/EX register.
module id_stage_pipe
    import mips_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int REG_N  = 32,
    localparam int AW     = $clog2(REG_N)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       Ins,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] Rdata1,
    output logic [DATA_W-1:0] Rdata2,
    output logic [DATA_W-1:0] Ed32,
    output logic [5:0]        op,
    output logic [5:0]        funct,
    output logic [4:0]        shamt,
    output logic [AW-1:0]     dst,
    output logic              wr_en,
    output logic              is_load,
    output logic [25:0]       jaddr
);

    logic [5:0]  ins_op;
    logic [4:0]  ins_rs, ins_rt, ins_rd;
    logic [15:0] ins_imm;

    assign ins_op  = Ins[31:26];
    assign ins_rs  = Ins[25:21];
    assign ins_rt  = Ins[20:16];
    assign ins_rd  = Ins[15:11];
    assign ins_imm = Ins[15:0];

    logic [DATA_W-1:0] rf_rdata1, rf_rdata2;

    regfile_2r1w #(
        .DATA_W (DATA_W),
        .REG_N  (REG_N)
    ) u_regfile (
        .clk    (CLK),
        .rst_n  (RST),
        .raddr1 (AW'(ins_rs)),
        .raddr2 (AW'(ins_rt)),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2),
        .we     (wb_en),
        .waddr  (wb_addr),
        .wdata  (wb_data)
    );

    logic              out_valid_q, out_valid_d;
    id_ex_ctrl_t       ctrl_q, ctrl_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [DATA_W-1:0] rdata2_q, rdata2_d;
    logic [DATA_W-1:0] ed32_q, ed32_d;

    id_ex_ctrl_t       dec_ctrl;
    logic [DATA_W-1:0] dec_ed32;
    logic              uses_rs, uses_rt;
    logic              stall, transfer;

    always_comb begin
        dec_ctrl         = '0;
        dec_ctrl.op      = ins_op;
        dec_ctrl.funct   = Ins[5:0];
        dec_ctrl.shamt   = Ins[10:6];
        dec_ctrl.jaddr   = Ins[25:0];
        dec_ctrl.is_load = (ins_op == OP_LW);

        case (ins_op)
            OP_RTYPE:                                  dec_ctrl.dst = ins_rd;
            OP_JAL:                                    dec_ctrl.dst = REG_RA;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW:   dec_ctrl.dst = ins_rt;
            default:                                   dec_ctrl.dst = '0;
        endcase
        // Non-writers already decode to r0, so a zero destination covers both.
        dec_ctrl.wr_en = (dec_ctrl.dst != '0);

        case (ext_kind(ins_op))
            EXT_SIGN: dec_ed32 = DATA_W'($signed(ins_imm));
            EXT_ZERO: dec_ed32 = DATA_W'(ins_imm);
            EXT_LUI:  dec_ed32 = DATA_W'($signed({ins_imm, 16'h0000}));
            default:  dec_ed32 = '0;
        endcase

        uses_rs = !(ins_op inside {OP_J, OP_JAL, OP_LUI});
        uses_rt = ins_op inside {OP_RTYPE, OP_SW, OP_BEQ, OP_BNE};
    end

    assign stall = out_valid_q && ctrl_q.is_load && ctrl_q.wr_en &&
                   ((uses_rs && ins_rs == ctrl_q.dst) ||
                    (uses_rt && ins_rt == ctrl_q.dst));

    assign in_ready = RST && !flush && !stall && (!out_valid_q || ex_ready);
    assign transfer = in_valid && in_ready;

    // NOTE: every _d gets its hold value first so no path through the
    // conditionals leaves a signal unassigned and infers a latch.
    always_comb begin
        out_valid_d = out_valid_q;
        ctrl_d      = ctrl_q;
        rdata1_d    = rdata1_q;
        rdata2_d    = rdata2_q;
        ed32_d      = ed32_q;
        if (transfer) begin
            out_valid_d = 1'b1;
            ctrl_d      = dec_ctrl;
            rdata1_d    = rf_rdata1;
            rdata2_d    = rf_rdata2;
            ed32_d      = dec_ed32;
        end else if (flush || ex_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: state updates use <= so all flops sample pre-edge values together.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            rdata1_q    <= '0;
            rdata2_q    <= '0;
            ed32_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            ctrl_q      <= ctrl_d;
            rdata1_q    <= rdata1_d;
            rdata2_q    <= rdata2_d;
            ed32_q      <= ed32_d;
        end
    end

    assign out_valid = out_valid_q;
    assign Rdata1    = rdata1_q;
    assign Rdata2    = rdata2_q;
    assign Ed32      = ed32_q;
    assign op        = ctrl_q.op;
    assign funct     = ctrl_q.funct;
    assign shamt     = ctrl_q.shamt;
    assign dst       = AW'(ctrl_q.dst);
    assign wr_en     = ctrl_q.wr_en;
    assign is_load   = ctrl_q.is_load;
    assign jaddr     = ctrl_q.jaddr;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed cases plus randomized traffic
// compared every cycle against a behavioural model of the decode stage.
module tb_id_stage_pipe;

    localparam int DATA_W = 32;
    localparam int REG_N  = 32;
    localparam int AW     = 5;

    logic              CLK = 1'b0;
    logic              RST;
    logic              in_valid, in_ready;
    logic [31:0]       Ins;
    logic              flush;
    logic              wb_en;
    logic [AW-1:0]     wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              ex_ready;
    logic              out_valid;
    logic [DATA_W-1:0] Rdata1, Rdata2, Ed32;
    logic [5:0]        op, funct;
    logic [4:0]        shamt;
    logic [AW-1:0]     dst;
    logic              wr_en, is_load;
    logic [25:0]       jaddr;

    id_stage_pipe #(.DATA_W(DATA_W), .REG_N(REG_N)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
        .Ins(Ins), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .ex_ready(ex_ready), .out_valid(out_valid),
        .Rdata1(Rdata1), .Rdata2(Rdata2), .Ed32(Ed32), .op(op), .funct(funct),
        .shamt(shamt), .dst(dst), .wr_en(wr_en), .is_load(is_load), .jaddr(jaddr)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] r1, r2, ed;
        logic [5:0]  op, funct;
        logic [4:0]  shamt, dst;
        logic        wr_en, is_load;
        logic [25:0] jaddr;
    } exp_t;

    logic [31:0] regs [32];
    bit          m_valid;
    exp_t        m_out;

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (wb_en && wb_addr == a) return wb_data;
        return regs[a];
    endfunction

    function automatic exp_t model_decode(input logic [31:0] ins);
        exp_t e;
        logic [5:0]  o   = ins[31:26];
        logic [15:0] imm = ins[15:0];
        e.r1 = model_read(ins[25:21]);
        e.r2 = model_read(ins[20:16]);
        if (o inside {6'h08, 6'h09, 6'h0A, 6'h0B, 6'h04, 6'h05, 6'h23, 6'h2B})
            e.ed = {{16{imm[15]}}, imm};
        else if (o inside {6'h0C, 6'h0D, 6'h0E})
            e.ed = {16'h0, imm};
        else if (o == 6'h0F)
            e.ed = {imm, 16'h0};
        else
            e.ed = 32'h0;
        if (o == 6'h00)                                e.dst = ins[15:11];
        else if (o == 6'h03)                           e.dst = 5'd31;
        else if ((o >= 6'h08 && o <= 6'h0F) || o == 6'h23) e.dst = ins[20:16];
        else                                           e.dst = 5'd0;
        e.wr_en   = (e.dst != 0);
        e.is_load = (o == 6'h23);
        e.op      = o;
        e.funct   = ins[5:0];
        e.shamt   = ins[10:6];
        e.jaddr   = ins[25:0];
        return e;
    endfunction

    function automatic bit model_ready();
        logic [5:0] o = Ins[31:26];
        bit rs_used = !(o inside {6'h02, 6'h03, 6'h0F});
        bit rt_used = o inside {6'h00, 6'h2B, 6'h04, 6'h05};
        bit hazard  = m_valid && m_out.is_load && m_out.wr_en &&
                      ((rs_used && Ins[25:21] == m_out.dst) ||
                       (rt_used && Ins[20:16] == m_out.dst));
        return RST && !flush && !hazard && (!m_valid || ex_ready);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        m_valid = 0;
        m_out   = '{default: '0};
    endtask

    task automatic compare_outputs();
        check("out_valid", out_valid, m_valid);
        if (m_valid) begin
            check("Rdata1", Rdata1, m_out.r1);
            check("Rdata2", Rdata2, m_out.r2);
            check("Ed32", Ed32, m_out.ed);
            check("op", op, m_out.op);
            check("funct", funct, m_out.funct);
            check("shamt", shamt, m_out.shamt);
            check("dst", dst, m_out.dst);
            check("wr_en", wr_en, m_out.wr_en);
            check("is_load", is_load, m_out.is_load);
            check("jaddr", jaddr, m_out.jaddr);
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        bit   nv;
        exp_t no;
        bit   rdy;
        #1;
        rdy = model_ready();
        check("in_ready", in_ready, rdy);
        nv = m_valid;
        no = m_out;
        if (flush) nv = 0;
        else if (in_valid && rdy) begin
            nv = 1;
            no = model_decode(Ins);
        end else if (m_valid && ex_ready) nv = 0;
        @(posedge CLK);
        if (wb_en && wb_addr != 0) regs[wb_addr] = wb_data;
        m_valid = nv;
        m_out   = no;
        @(negedge CLK);
        compare_outputs();
    endtask

    task automatic drive(input logic [31:0] ins, input bit iv, input bit er, input bit fl,
                         input bit we, input logic [4:0] wa, input logic [31:0] wd);
        Ins = ins; in_valid = iv; ex_ready = er; flush = fl;
        wb_en = we; wb_addr = wa; wb_data = wd;
    endtask

    function automatic logic [31:0] rand_ins();
        logic [5:0] ops [18] = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
                                 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h23,
                                 6'h2B, 6'h3F};
        logic [5:0] o  = ops[$urandom_range(0, 17)];
        logic [4:0] rs = 5'($urandom_range(0, 7));
        logic [4:0] rt = 5'($urandom_range(0, 7));
        logic [4:0] rd = 5'($urandom_range(0, 7));
        if (o == 6'h00) return {o, rs, rt, rd, 5'($urandom), 6'($urandom)};
        if (o == 6'h02 || o == 6'h03) return {o, 26'($urandom)};
        return {o, rs, rt, 16'($urandom)};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b0;
        drive(32'h0, 0, 1, 0, 0, 0, 0);
        model_reset();
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 0);
        check("reset_Rdata1", Rdata1, 0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;

        // Bypass: write r5 while add $3,$5,$0 is captured
        drive(32'h00A01820, 1, 1, 0, 1, 5'd5, 32'h1234);
        step();
        check("bypass_Rdata1", Rdata1, 32'h1234);
        check("bypass_dst", dst, 3);
        check("bypass_wr_en", wr_en, 1);

        // Immediate extension
        drive(32'h2022FFFC, 1, 1, 0, 0, 0, 0); step();
        check("addi_ed32", Ed32, 32'hFFFFFFFC);
        drive(32'h3422FFFC, 1, 1, 0, 0, 0, 0); step();
        check("ori_ed32", Ed32, 32'h0000FFFC);
        drive(32'h3C021234, 1, 1, 0, 0, 0, 0); step();
        check("lui_ed32", Ed32, 32'h12340000);
        drive(32'hAC220008, 1, 1, 0, 0, 0, 0); step();
        check("sw_wr_en", wr_en, 0);

        // Load-use stall: lw $4 then add $5,$4,$4
        drive(32'h8C240000, 1, 1, 0, 0, 0, 0); step();
        check("lw_op", op, 6'h23);
        drive(32'h00842820, 1, 1, 0, 0, 0, 0);
        #1 check("stall_in_ready", in_ready, 0);
        step();
        check("stall_bubble", out_valid, 0);
        step();
        check("add_after_stall_valid", out_valid, 1);
        check("add_after_stall_dst", dst, 5);

        // Backpressure for 3 cycles
        drive(32'h00221820, 1, 1, 0, 0, 0, 0); step();
        drive(32'h00432020, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_in_ready", in_ready, 0);
            step();
            check("bp_dst_hold", dst, 3);
            check("bp_valid_hold", out_valid, 1);
        end
        ex_ready = 1'b1;
        step();
        check("bp_release_dst", dst, 4);

        // r0 stays zero
        drive(32'h0, 0, 1, 0, 1, 5'd0, 32'hFFFFFFFF); step();
        drive(32'h00001820, 1, 1, 0, 0, 0, 0); step();
        check("r0_Rdata1", Rdata1, 0);
        check("r0_Rdata2", Rdata2, 0);

        // jal
        drive(32'h0C000010, 1, 1, 0, 0, 0, 0); step();
        check("jal_dst", dst, 31);
        check("jal_wr_en", wr_en, 1);
        check("jal_jaddr", jaddr, 26'h10);

        // Flush drops the offered instruction
        drive(32'h00221820, 1, 1, 1, 0, 0, 0); step();
        check("flush_out_valid", out_valid, 0);
        drive(32'h0, 0, 1, 0, 0, 0, 0); step();
        check("flush_dropped", out_valid, 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            drive(rand_ins(), $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7)),
                  $urandom);
            step();
        end

        // Asynchronous reset while holding a valid instruction
        drive(32'h0C000010, 1, 1, 0, 0, 0, 0); step();
        check("pre_reset_valid", out_valid, 1);
        drive(32'h00221820, 1, 0, 0, 0, 0, 0);
        #2 RST = 1'b0;
        #1;
        check("async_reset_valid", out_valid, 0);
        check("async_reset_dst", dst, 0);
        check("async_reset_jaddr", jaddr, 0);
        check("async_reset_in_ready", in_ready, 0);
        model_reset();
        @(negedge CLK);
        RST = 1'b1;
        for (int r = 1; r < 8; r++) begin
            drive({6'h00, 5'(r), 5'(r + 8), 5'd1, 5'd0, 6'h20}, 1, 1, 0, 0, 0, 0);
            step();
            check("post_reset_Rdata1", Rdata1, 0);
            check("post_reset_Rdata2", Rdata2, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
